// File: rtl/bsg_axis_packet_source_mc.sv
// rtl/bsg_axis_packet_source_mc.sv - multi-channel buffered AXIS packet source, round-robin per packet
// Optional per-channel packet and beat counters: define BSG_AXIS_PACKET_SOURCE_STATS_EN.
module bsg_axis_packet_source_mc #(
    parameter int data_width_p = 32,
    parameter int num_ch_p     = 2,
    parameter int fifo_els_p   = 8,
    parameter int len_width_p  = 16,
    localparam int ch_w_lp     = (num_ch_p > 1) ? $clog2(num_ch_p) : 1,
    localparam int keep_w_lp   = data_width_p / 8
) (
    input  logic                             aclk_i,
    input  logic                             areset_i,
    input  logic [num_ch_p-1:0]              data_v_i,
    input  logic [num_ch_p*data_width_p-1:0] data_i,
    output logic [num_ch_p-1:0]              data_ready_o,
    input  logic                             cmd_v_i,
    input  logic [ch_w_lp-1:0]               cmd_ch_i,
    input  logic [len_width_p-1:0]           cmd_len_i,
    output logic                             cmd_ready_o,
    input  logic                             tready_i,
    output logic                             tvalid_o,
    output logic [data_width_p-1:0]          tdata_o,
    output logic [keep_w_lp-1:0]             tkeep_o,
    output logic                             tlast_o,
    output logic [ch_w_lp-1:0]               tdest_o,
    output logic                             err_zero_len_o
`ifdef BSG_AXIS_PACKET_SOURCE_STATS_EN
    ,
    output logic [num_ch_p*32-1:0]           pkt_count_o,
    output logic [31:0]                      beat_count_o
`endif
);

    localparam int addr_w_lp   = $clog2(fifo_els_p);
    localparam int cnt_w_lp    = $clog2(fifo_els_p + 1);
    localparam int ch_cmp_w_lp = ch_w_lp + 1;
    localparam logic [addr_w_lp-1:0]   last_addr_lp  = addr_w_lp'(fifo_els_p - 1);
    localparam logic [cnt_w_lp-1:0]    full_cnt_lp   = cnt_w_lp'(fifo_els_p);
    localparam logic [len_width_p-1:0] beat_bytes_lp = len_width_p'(keep_w_lp);
    localparam logic [ch_cmp_w_lp-1:0] num_ch_lp     = ch_cmp_w_lp'(num_ch_p);
    localparam logic [ch_w_lp-1:0]     last_ch_lp    = ch_w_lp'(num_ch_p - 1);

    typedef enum logic {ST_IDLE, ST_SEND} state_e;

    logic [data_width_p-1:0] r_mem [num_ch_p][fifo_els_p];
    logic [addr_w_lp-1:0]    r_wr_ptr [num_ch_p];
    logic [addr_w_lp-1:0]    r_rd_ptr [num_ch_p];
    logic [cnt_w_lp-1:0]     r_cnt [num_ch_p];
    logic [num_ch_p-1:0]     r_slot_v;
    logic [len_width_p-1:0]  r_slot_len [num_ch_p];
    logic                    r_err;
    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [ch_w_lp-1:0]      r_ch;
    logic [ch_w_lp-1:0]      r_rr_ptr;
    logic [ch_w_lp-1:0]      r_tdest;
    logic [len_width_p-1:0]  r_remaining;

    logic [num_ch_p-1:0]     w_full;
    logic [num_ch_p-1:0]     w_nonempty;
    logic [num_ch_p-1:0]     w_enq;
    logic [num_ch_p-1:0]     w_deq;
    logic [num_ch_p-1:0]     w_eligible;
    logic                    w_cmd_ch_ok;
    logic                    w_cmd_take;
    logic                    w_tvalid;
    logic                    w_xfer;
    logic                    w_last;
    logic                    w_pick_v;
    logic [ch_w_lp-1:0]      w_pick_ch;
    logic [ch_w_lp-1:0]      w_ch_inc;
    logic [data_width_p-1:0] w_head;
    logic [keep_w_lp-1:0]    w_keep;

    always_comb begin
        for (int c = 0; c < num_ch_p; c++) begin
            w_full[c]     = (r_cnt[c] == full_cnt_lp);
            w_nonempty[c] = (r_cnt[c] != '0);
            w_enq[c]      = data_v_i[c] & ~w_full[c];
            w_deq[c]      = w_xfer & (r_ch == ch_w_lp'(c));
            w_eligible[c] = r_slot_v[c] & w_nonempty[c];
        end
    end

    assign w_head   = r_mem[r_ch][r_rd_ptr[r_ch]];
    assign w_tvalid = (r_state == ST_SEND) & w_nonempty[r_ch];
    assign w_xfer   = w_tvalid & tready_i;
    assign w_last   = (r_remaining <= beat_bytes_lp);
    assign w_ch_inc = (r_ch == last_ch_lp) ? '0 : r_ch + 1'b1;

    // Out-of-range channel ids are swallowed: ready is forced high and nothing is captured.
    assign w_cmd_ch_ok = ({1'b0, cmd_ch_i} < num_ch_lp);
    assign cmd_ready_o = w_cmd_ch_ok ? ~r_slot_v[cmd_ch_i] : 1'b1;
    assign w_cmd_take  = cmd_v_i & w_cmd_ch_ok & ~r_slot_v[cmd_ch_i];

    // Scan downward so the eligible channel closest above rr_ptr is the one left standing.
    always_comb begin
        int idx;
        idx       = 0;
        w_pick_v  = 1'b0;
        w_pick_ch = '0;
        for (int i = num_ch_p - 1; i >= 0; i--) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= num_ch_p) idx = idx - num_ch_p;
            if (w_eligible[idx]) begin
                w_pick_v  = 1'b1;
                w_pick_ch = ch_w_lp'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_pick_v) w_state_nxt = ST_SEND;
            ST_SEND: if (w_xfer && w_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            r_state     <= ST_IDLE;
            r_ch        <= '0;
            r_rr_ptr    <= '0;
            r_tdest     <= '0;
            r_remaining <= '0;
            r_slot_v    <= '0;
            r_err       <= 1'b0;
            for (int c = 0; c < num_ch_p; c++) r_slot_len[c] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_pick_v) begin
                r_ch        <= w_pick_ch;
                r_tdest     <= w_pick_ch;
                r_remaining <= r_slot_len[w_pick_ch];
            end else if (w_xfer) begin
                r_remaining <= r_remaining - beat_bytes_lp;
                if (w_last) r_rr_ptr <= w_ch_inc;
            end
            for (int c = 0; c < num_ch_p; c++) begin
                if (w_xfer && w_last && r_ch == ch_w_lp'(c)) begin
                    r_slot_v[c] <= 1'b0;
                end else if (w_cmd_take && cmd_len_i != '0 && cmd_ch_i == ch_w_lp'(c)) begin
                    r_slot_v[c]   <= 1'b1;
                    r_slot_len[c] <= cmd_len_i;
                end
            end
            if (w_cmd_take && cmd_len_i == '0) r_err <= 1'b1;
        end
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            for (int c = 0; c < num_ch_p; c++) begin
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_cnt[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < num_ch_p; c++) begin
                if (w_enq[c]) r_wr_ptr[c] <= (r_wr_ptr[c] == last_addr_lp) ? '0 : r_wr_ptr[c] + 1'b1;
                if (w_deq[c]) r_rd_ptr[c] <= (r_rd_ptr[c] == last_addr_lp) ? '0 : r_rd_ptr[c] + 1'b1;
                case ({w_enq[c], w_deq[c]})
                    2'b10:   r_cnt[c] <= r_cnt[c] + 1'b1;
                    2'b01:   r_cnt[c] <= r_cnt[c] - 1'b1;
                    default: r_cnt[c] <= r_cnt[c];
                endcase
            end
        end
    end

    // Storage carries no reset; the read side is gated by the counters.
    always_ff @(posedge aclk_i) begin
        for (int c = 0; c < num_ch_p; c++) begin
            if (w_enq[c]) r_mem[c][r_wr_ptr[c]] <= data_i[c*data_width_p +: data_width_p];
        end
    end

    always_comb begin
        w_keep = '0;
        if (r_state == ST_SEND) begin
            w_keep = '1;
            if (w_last) begin
                for (int b = 0; b < keep_w_lp; b++) w_keep[b] = (len_width_p'(b) < r_remaining);
            end
        end
    end

    assign data_ready_o   = ~w_full;
    assign tvalid_o       = w_tvalid;
    assign tdata_o        = (r_state == ST_SEND) ? w_head : '0;
    assign tkeep_o        = w_keep;
    assign tlast_o        = (r_state == ST_SEND) & w_last;
    assign tdest_o        = r_tdest;
    assign err_zero_len_o = r_err;

`ifdef BSG_AXIS_PACKET_SOURCE_STATS_EN
    logic [31:0] r_pkt_cnt [num_ch_p];
    logic [31:0] r_beat_cnt;

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            r_beat_cnt <= '0;
            for (int c = 0; c < num_ch_p; c++) r_pkt_cnt[c] <= '0;
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
            if (w_last) r_pkt_cnt[r_ch] <= r_pkt_cnt[r_ch] + 32'd1;
        end
    end

    for (genvar g = 0; g < num_ch_p; g++) begin : g_pkt_cnt
        assign pkt_count_o[g*32 +: 32] = r_pkt_cnt[g];
    end
    assign beat_count_o = r_beat_cnt;
`endif

endmodule

// File: tb/tb_bsg_axis_packet_source_mc.sv
// tb/tb_bsg_axis_packet_source_mc.sv - directed scoreboard bench for bsg_axis_packet_source_mc
module tb_bsg_axis_packet_source_mc;

    localparam int DW = 32;
    localparam int NC = 3;
    localparam int FE = 8;
    localparam int LW = 16;
    localparam int KW = DW / 8;
    localparam int CW = 2;

    logic               aclk = 1'b0;
    logic               areset_i;
    logic [NC-1:0]      data_v_i;
    logic [NC*DW-1:0]   data_i;
    logic [NC-1:0]      data_ready_o;
    logic               cmd_v_i;
    logic [CW-1:0]      cmd_ch_i;
    logic [LW-1:0]      cmd_len_i;
    logic               cmd_ready_o;
    logic               tready_i;
    logic               tvalid_o;
    logic [DW-1:0]      tdata_o;
    logic [KW-1:0]      tkeep_o;
    logic               tlast_o;
    logic [CW-1:0]      tdest_o;
    logic               err_zero_len_o;

    always #5 aclk = ~aclk;

    bsg_axis_packet_source_mc #(
        .data_width_p(DW), .num_ch_p(NC), .fifo_els_p(FE), .len_width_p(LW)
    ) dut (
        .aclk_i(aclk), .areset_i(areset_i),
        .data_v_i(data_v_i), .data_i(data_i), .data_ready_o(data_ready_o),
        .cmd_v_i(cmd_v_i), .cmd_ch_i(cmd_ch_i), .cmd_len_i(cmd_len_i), .cmd_ready_o(cmd_ready_o),
        .tready_i(tready_i), .tvalid_o(tvalid_o), .tdata_o(tdata_o), .tkeep_o(tkeep_o),
        .tlast_o(tlast_o), .tdest_o(tdest_o), .err_zero_len_o(err_zero_len_o)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [CW-1:0] dest;
    } beat_t;

    beat_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int first_tv = -1;
    int beats = 0;
    int last_tlast_cyc = -100;
    int t0 = 0;
    int b0 = 0;
    int kk = 0;
    int bp_pat [4] = '{1, 0, 0, 1};
    logic          held = 1'b0;
    logic          prev_last = 1'b0;
    logic [DW-1:0] h_data;
    logic [KW-1:0] h_keep;
    logic          h_last;
    logic [CW-1:0] h_dest;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        beat_t e;
        if (held) begin
            chk("stall_tvalid", tvalid_o, 1);
            chk("stall_tdata", tdata_o, h_data);
            chk("stall_tkeep", tkeep_o, h_keep);
            chk("stall_tlast", tlast_o, h_last);
            chk("stall_tdest", tdest_o, h_dest);
        end
        held = 1'b0;
        if (tvalid_o) begin
            if (first_tv < 0) first_tv = cyc;
            if (tready_i) begin
                beats++;
                if (prev_last) chk("pkt_gap", (cyc - last_tlast_cyc >= 2), 1);
                prev_last = tlast_o;
                if (tlast_o) last_tlast_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_tdata", tdata_o, e.data);
                    chk("beat_tkeep", tkeep_o, e.keep);
                    chk("beat_tlast", tlast_o, e.last);
                    chk("beat_tdest", tdest_o, e.dest);
                end
            end else begin
                held   = 1'b1;
                h_data = tdata_o;
                h_keep = tkeep_o;
                h_last = tlast_o;
                h_dest = tdest_o;
            end
        end
    endtask

    task automatic step();
        @(negedge aclk);
        sample();
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        areset_i = 1'b1;
        #1;
        chk("rst_tvalid", tvalid_o, 0);
        chk("rst_tlast", tlast_o, 0);
        chk("rst_tkeep", tkeep_o, 0);
        chk("rst_tdata", tdata_o, 0);
        chk("rst_tdest", tdest_o, 0);
        chk("rst_err", err_zero_len_o, 0);
        exp_q.delete();
        held = 1'b0;
        prev_last = 1'b0;
        data_v_i = '0;
        cmd_v_i = 1'b0;
        step();
        step();
        areset_i = 1'b0;
        #1;
        chk("rst_data_ready", data_ready_o, 3'b111);
    endtask

    task automatic expect_pkt(input int ch, input int len, input int base);
        beat_t e;
        int nb;
        int rem;
        nb = (len + KW - 1) / KW;
        rem = len;
        for (int i = 0; i < nb; i++) begin
            e.data = DW'(base + i);
            e.dest = CW'(ch);
            e.last = (i == nb - 1);
            e.keep = e.last ? KW'((1 << rem) - 1) : {KW{1'b1}};
            rem -= KW;
            exp_q.push_back(e);
        end
    endtask

    task automatic push(input int ch, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            data_v_i = '0;
            data_v_i[ch] = 1'b1;
            data_i[ch*DW +: DW] = DW'(base + i);
            step();
        end
        data_v_i = '0;
    endtask

    task automatic push2(input int n, input int base0, input int base1);
        for (int i = 0; i < n; i++) begin
            data_v_i = 3'b011;
            data_i[0 +: DW] = DW'(base0 + i);
            data_i[DW +: DW] = DW'(base1 + i);
            step();
        end
        data_v_i = '0;
    endtask

    task automatic send_cmd(input int ch, input int len);
        cmd_v_i = 1'b1;
        cmd_ch_i = CW'(ch);
        cmd_len_i = LW'(len);
        #1;
        chk("cmd_ready", cmd_ready_o, 1);
        step();
        cmd_v_i = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < maxc) begin
            step();
            k++;
        end
        chk("drain_left", 32'(exp_q.size()), 0);
    endtask

    initial begin
        areset_i = 1'b1;
        data_v_i = '0;
        data_i = '0;
        cmd_v_i = 1'b0;
        cmd_ch_i = '0;
        cmd_len_i = '0;
        tready_i = 1'b1;
        #2;
        do_reset();

        // single packet, command and first word in the same cycle
        expect_pkt(0, 10, 100);
        first_tv = -1;
        cmd_v_i = 1'b1;
        cmd_ch_i = 2'd0;
        cmd_len_i = 16'd10;
        data_v_i = 3'b001;
        data_i[0 +: DW] = 32'd100;
        t0 = cyc;
        step();
        cmd_v_i = 1'b0;
        data_i[0 +: DW] = 32'd101;
        step();
        data_i[0 +: DW] = 32'd102;
        step();
        data_v_i = '0;
        drain(20);
        chk("t1_latency", 32'(first_tv - t0), 2);

        // round robin from pointer 0, then again from pointer 2 (wraps to ch0)
        do_reset();
        send_cmd(0, 8);
        send_cmd(1, 8);
        expect_pkt(0, 8, 200);
        expect_pkt(1, 8, 300);
        push2(2, 200, 300);
        drain(30);
        send_cmd(0, 8);
        send_cmd(1, 8);
        expect_pkt(0, 8, 210);
        expect_pkt(1, 8, 310);
        push2(2, 210, 310);
        drain(30);

        // backpressure on a 4-beat packet
        tready_i = 1'b0;
        push(2, 4, 400);
        expect_pkt(2, 16, 400);
        send_cmd(2, 16);
        run(3);
        b0 = beats;
        for (int i = 0; i < 4; i++) begin
            tready_i = bp_pat[i][0];
            step();
        end
        tready_i = 1'b1;
        drain(20);
        chk("t3_beats", 32'(beats - b0), 4);
        run(4);
        chk("t3_idle_after", tvalid_o, 0);

        // underrun mid-packet
        b0 = beats;
        push(0, 1, 500);
        expect_pkt(0, 12, 500);
        send_cmd(0, 12);
        run(6);
        chk("t4_underrun_tvalid", tvalid_o, 0);
        chk("t4_underrun_beats", 32'(beats - b0), 1);
        push(0, 2, 501);
        drain(20);

        // zero length, then excess words carried into following packets
        chk("t5_err_pre", err_zero_len_o, 0);
        send_cmd(1, 0);
        chk("t5_err_set", err_zero_len_o, 1);
        cmd_ch_i = 2'd1;
        #1;
        chk("t5_slot_empty", cmd_ready_o, 1);
        push(1, 1, 600);
        run(5);
        chk("t5_err_sticky", err_zero_len_o, 1);
        chk("t5_no_output", tvalid_o, 0);
        push(1, 2, 601);
        expect_pkt(1, 4, 600);
        send_cmd(1, 4);
        drain(20);
        expect_pkt(1, 7, 601);
        send_cmd(1, 7);
        drain(20);

        // command to a nonexistent channel
        b0 = beats;
        push(0, 1, 650);
        push(1, 1, 660);
        push(2, 1, 670);
        cmd_v_i = 1'b1;
        cmd_ch_i = 2'd3;
        cmd_len_i = 16'd4;
        #1;
        chk("t5_badch_ready", cmd_ready_o, 1);
        step();
        cmd_v_i = 1'b0;
        run(6);
        chk("t5_badch_beats", 32'(beats - b0), 0);
        for (int c = 0; c < NC; c++) begin
            cmd_ch_i = CW'(c);
            #1;
            chk("t5_badch_slot", cmd_ready_o, 1);
        end

        // reset in the middle of a packet
        do_reset();
        push(0, 4, 700);
        expect_pkt(0, 16, 700);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        send_cmd(0, 16);
        b0 = beats;
        kk = 0;
        while (beats - b0 < 2 && kk < 20) begin
            step();
            kk++;
        end
        chk("t6_two_beats", 32'(beats - b0), 2);
        chk("t6_tvalid_pre", tvalid_o, 1);
        do_reset();
        cmd_ch_i = 2'd0;
        #1;
        chk("t6_slot_cleared", cmd_ready_o, 1);
        b0 = beats;
        send_cmd(0, 4);
        run(5);
        chk("t6_fifo_cleared", 32'(beats - b0), 0);
        expect_pkt(0, 4, 800);
        push(0, 1, 800);
        drain(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
